// File: rtl/vreg_wb_arbiter.sv
// vreg_wb_arbiter
//   Write-back arbiter and destination-register scoreboard for a vector
//   register file. Two write-back sources compete for the single register
//   file write port:
//   - the vector ALU;
//   - the vector load unit.
//   The decoder reserves destination registers ahead of time, so WAW and RAW
//   hazards can be detected.
//
// Handshake (valid/ready, all three channels):
//   A transfer happens in a cycle where valid & ready are both high at the
//   posedge. The ready outputs are combinational. A requester that raised
//   valid must hold valid/addr/data stable until it sees ready.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   issue_valid/addr/ready      destination reservation from decode
//   alu_valid/addr/data/ready   ALU write-back request
//   ld_valid/addr/data/ready    load-unit write-back request
//   wre, a3, wd3                registered register-file write port
//   chk_a1, chk_a2, hazard      source-register pending-write check
//   busy                        scoreboard, one bit per register
//
// AW is expected to be clog2(NREG).
module vreg_wb_arbiter #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_addr,
  output logic            issue_ready,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_addr,
  input  logic [DW-1:0]   alu_data,
  output logic            alu_ready,
  input  logic            ld_valid,
  input  logic [AW-1:0]   ld_addr,
  input  logic [DW-1:0]   ld_data,
  output logic            ld_ready,
  output logic            wre,
  output logic [AW-1:0]   a3,
  output logic [DW-1:0]   wd3,
  input  logic [AW-1:0]   chk_a1,
  input  logic [AW-1:0]   chk_a2,
  output logic            hazard,
  output logic [NREG-1:0] busy
);

  // Round-robin pointer: names the requester that wins the next contested
  // cycle.
  typedef enum logic {RR_ALU = 1'b0, RR_LD = 1'b1} rr_t;

  rr_t             rr_q, rr_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            alu_gnt, ld_gnt, any_gnt;
  logic [AW-1:0]   gnt_addr;
  logic [DW-1:0]   gnt_data;
  logic            issue_fire;

  assign busy        = busy_q;
  assign issue_ready = ~rst & ~busy_q[issue_addr];
  assign issue_fire  = issue_valid & issue_ready;
  assign hazard      = busy_q[chk_a1] | busy_q[chk_a2];
  assign alu_ready   = alu_gnt;
  assign ld_ready    = ld_gnt;
  assign any_gnt     = alu_gnt | ld_gnt;

  // Grant selection and round-robin next state.
  always_comb begin
    alu_gnt = 1'b0;
    ld_gnt  = 1'b0;
    rr_d    = rr_q;
    if (!rst) begin
      if (alu_valid && ld_valid) begin
        // Contested: the pointer's requester wins, and the pointer moves to
        // the loser.
        if (rr_q == RR_ALU) begin
          alu_gnt = 1'b1;
          rr_d    = RR_LD;
        end else begin
          ld_gnt  = 1'b1;
          rr_d    = RR_ALU;
        end
      end else begin
        alu_gnt = alu_valid;
        ld_gnt  = ld_valid;
      end
    end
  end

  always_comb begin
    gnt_addr = ld_gnt ? ld_addr : alu_addr;
    gnt_data = ld_gnt ? ld_data : alu_data;
  end

  // Scoreboard next state. The clear is applied first so that a reservation
  // accepted on the same edge as a write to the same register survives.
  // Clearing an idle bit is harmless, so writes to unreserved registers
  // leave the scoreboard unchanged.
  always_comb begin
    busy_d = busy_q;
    if (any_gnt) busy_d[gnt_addr] = 1'b0;
    if (issue_fire) busy_d[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q   <= RR_ALU;
      busy_q <= '0;
      wre    <= 1'b0;
      a3     <= '0;
      wd3    <= '0;
    end else begin
      rr_q   <= rr_d;
      busy_q <= busy_d;
      wre    <= any_gnt;
      // The port keeps its last address and data when idle.
      if (any_gnt) begin
        a3  <= gnt_addr;
        wd3 <= gnt_data;
      end
    end
  end

endmodule

// File: tb/tb_vreg_wb_arbiter.sv
module tb_vreg_wb_arbiter;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 128;

  logic            clk;
  logic            rst;
  logic            issue_valid;
  logic [AW-1:0]   issue_addr;
  logic            issue_ready;
  logic            alu_valid;
  logic [AW-1:0]   alu_addr;
  logic [DW-1:0]   alu_data;
  logic            alu_ready;
  logic            ld_valid;
  logic [AW-1:0]   ld_addr;
  logic [DW-1:0]   ld_data;
  logic            ld_ready;
  logic            wre;
  logic [AW-1:0]   a3;
  logic [DW-1:0]   wd3;
  logic [AW-1:0]   chk_a1;
  logic [AW-1:0]   chk_a2;
  logic            hazard;
  logic [NREG-1:0] busy;

  int checks;
  int failures;

  vreg_wb_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .wre(wre), .a3(a3), .wd3(wd3),
    .chk_a1(chk_a1), .chk_a2(chk_a2), .hazard(hazard), .busy(busy)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [AW-1:0] ia,
                       input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                       input logic [AW-1:0] c1, input logic [AW-1:0] c2);
    issue_valid = iv; issue_addr = ia;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    ld_valid = lv; ld_addr = la; ld_data = ldd;
    chk_a1 = c1; chk_a2 = c2;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic iv; logic [4:0] ia;
    logic av; logic [4:0] aa; logic [7:0] ab;
    logic lv; logic [4:0] la; logic [7:0] lb;
    logic [4:0] c1; logic [4:0] c2;
    logic e_ir; logic e_ar; logic e_lr; logic e_hz;
    logic e_wre; logic [4:0] e_a3; logic [7:0] e_wb;
    logic [31:0] e_busy;
  } vec_t;

  vec_t tbl[16];

  // ---------------- reference model ----------------
  bit              m_busy[NREG];
  int              m_pref;      // 0: ALU wins next contest, 1: load wins
  logic            m_wre;
  logic [AW-1:0]   m_a3;
  logic [DW-1:0]   m_wd3;

  function automatic logic [NREG-1:0] m_busy_vec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    m_pref = 0;
    m_wre = 1'b0;
    m_a3 = '0;
    m_wd3 = '0;
  endtask

  initial begin
    bit pa, pl;
    logic [AW-1:0] pa_addr, pl_addr;
    logic [DW-1:0] pa_data, pl_data;
    bit r_rst, e_ir, e_ar, e_lr, e_hz, winner_ld, got;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    idle();

    tbl[0]  = '{1'b1,5'd7, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0, 1'b0,5'd0,8'h00, 32'h0000_0080};
    tbl[1]  = '{1'b0,5'd0, 1'b1,5'd7,8'hA5, 1'b0,5'd0,8'h00, 5'd7,5'd0, 1'b1,1'b1,1'b0,1'b1, 1'b1,5'd7,8'hA5, 32'h0000_0000};
    tbl[2]  = '{1'b0,5'd0, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 5'd7,5'd7, 1'b1,1'b0,1'b0,1'b0, 1'b0,5'd7,8'hA5, 32'h0000_0000};
    tbl[3]  = '{1'b0,5'd0, 1'b1,5'd3,8'h33, 1'b1,5'd4,8'h44, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b0, 1'b1,5'd3,8'h33, 32'h0000_0000};
    tbl[4]  = '{1'b0,5'd0, 1'b1,5'd3,8'h33, 1'b1,5'd4,8'h44, 5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0, 1'b1,5'd4,8'h44, 32'h0000_0000};
    tbl[5]  = '{1'b0,5'd0, 1'b1,5'd3,8'h33, 1'b1,5'd4,8'h44, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b0, 1'b1,5'd3,8'h33, 32'h0000_0000};
    tbl[6]  = '{1'b0,5'd0, 1'b1,5'd3,8'h33, 1'b1,5'd4,8'h44, 5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0, 1'b1,5'd4,8'h44, 32'h0000_0000};
    tbl[7]  = '{1'b1,5'd9, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0, 1'b0,5'd4,8'h44, 32'h0000_0200};
    tbl[8]  = '{1'b1,5'd9, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 5'd9,5'd0, 1'b0,1'b0,1'b0,1'b1, 1'b0,5'd4,8'h44, 32'h0000_0200};
    tbl[9]  = '{1'b1,5'd9, 1'b0,5'd0,8'h00, 1'b1,5'd9,8'h99, 5'd0,5'd0, 1'b0,1'b0,1'b1,1'b0, 1'b1,5'd9,8'h99, 32'h0000_0000};
    tbl[10] = '{1'b1,5'd9, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0, 1'b0,5'd9,8'h99, 32'h0000_0200};
    tbl[11] = '{1'b1,5'd5, 1'b1,5'd5,8'h55, 1'b0,5'd0,8'h00, 5'd0,5'd0, 1'b1,1'b1,1'b0,1'b0, 1'b1,5'd5,8'h55, 32'h0000_0220};
    tbl[12] = '{1'b1,5'd2, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0, 1'b0,5'd5,8'h55, 32'h0000_0224};
    tbl[13] = '{1'b0,5'd0, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 5'd2,5'd6, 1'b1,1'b0,1'b0,1'b1, 1'b0,5'd5,8'h55, 32'h0000_0224};
    tbl[14] = '{1'b0,5'd0, 1'b0,5'd0,8'h00, 1'b0,5'd0,8'h00, 5'd1,5'd6, 1'b1,1'b0,1'b0,1'b0, 1'b0,5'd5,8'h55, 32'h0000_0224};
    tbl[15] = '{1'b0,5'd0, 1'b0,5'd0,8'h00, 1'b1,5'd0,8'h0F, 5'd0,5'd0, 1'b1,1'b0,1'b1,1'b0, 1'b1,5'd0,8'h0F, 32'h0000_0224};

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, '0);
    chk("rst_wre", wre, 1'b0);
    chk("rst_a3", a3, '0);
    chk("rst_wd3", wd3, '0);
    chk("rst_issue_ready", issue_ready, 1'b0);
    rst = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].iv, tbl[i].ia, tbl[i].av, tbl[i].aa, {16{tbl[i].ab}},
            tbl[i].lv, tbl[i].la, {16{tbl[i].lb}}, tbl[i].c1, tbl[i].c2);
      #1;
      chk($sformatf("tbl%0d_issue_ready", i), issue_ready, tbl[i].e_ir);
      chk($sformatf("tbl%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
      chk($sformatf("tbl%0d_ld_ready", i), ld_ready, tbl[i].e_lr);
      chk($sformatf("tbl%0d_hazard", i), hazard, tbl[i].e_hz);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_wre", i), wre, tbl[i].e_wre);
      chk($sformatf("tbl%0d_a3", i), a3, tbl[i].e_a3);
      chk($sformatf("tbl%0d_wd3", i), wd3, {16{tbl[i].e_wb}});
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
    end

    // ---------------- contested grants straight after reset ----------------
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b1, 5'd3, {16{8'h33}}, 1'b1, 5'd4, {16{8'h44}}, 5'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr%0d_alu_ready", i), alu_ready, (i % 2 == 0));
      chk($sformatf("rr%0d_ld_ready", i), ld_ready, (i % 2 == 1));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_wre", i), wre, 1'b1);
      chk($sformatf("rr%0d_a3", i), a3, (i % 2 == 0) ? 5'd3 : 5'd4);
    end

    // ---------------- reset with full scoreboard and live requests ----------
    for (int r = 0; r < NREG; r++) begin
      drive(1'b1, AW'(r), 1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0, 5'd0);
      @(posedge clk);
      #1;
    end
    chk("full_busy", busy, {NREG{1'b1}});
    drive(1'b0, 5'd0, 1'b1, 5'd3, {16{8'h33}}, 1'b1, 5'd4, {16{8'h44}}, 5'd0, 5'd0);
    rst = 1'b1;
    #1;
    chk("inrst_alu_ready", alu_ready, 1'b0);
    chk("inrst_ld_ready", ld_ready, 1'b0);
    chk("inrst_issue_ready", issue_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("postrst_busy", busy, '0);
    chk("postrst_wre", wre, 1'b0);
    rst = 1'b0;
    #1;
    chk("release_alu_ready", alu_ready, 1'b1);
    chk("release_ld_ready", ld_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("release_wre", wre, 1'b1);
    chk("release_a3", a3, 5'd3);

    // ---------------- randomized against the model ----------------
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    pa = 0; pl = 0;
    pa_addr = '0; pl_addr = '0; pa_data = '0; pl_data = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_wre", wre, m_wre);
      chk("rnd_a3", a3, m_a3);
      chk("rnd_wd3", wd3, m_wd3);
      chk("rnd_busy", busy, m_busy_vec());

      r_rst = ($urandom_range(0, 59) == 0);
      if (!pa && $urandom_range(0, 1) == 1) begin
        pa = 1;
        pa_addr = AW'($urandom_range(0, NREG - 1));
        pa_data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (!pl && $urandom_range(0, 1) == 1) begin
        pl = 1;
        pl_addr = AW'($urandom_range(0, NREG - 1));
        pl_data = {$urandom, $urandom, $urandom, $urandom};
      end
      rst = r_rst;
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, NREG - 1)),
            pa, pa_addr, pa_data, pl, pl_addr, pl_data,
            AW'($urandom_range(0, NREG - 1)), AW'($urandom_range(0, NREG - 1)));
      #1;

      e_ir = !r_rst && !m_busy[issue_addr];
      e_hz = m_busy[chk_a1] || m_busy[chk_a2];
      got = !r_rst && (pa || pl);
      winner_ld = pl && (!pa || m_pref == 1);
      e_ar = got && !winner_ld;
      e_lr = got && winner_ld;
      chk("rnd_issue_ready", issue_ready, e_ir);
      chk("rnd_hazard", hazard, e_hz);
      chk("rnd_alu_ready", alu_ready, e_ar);
      chk("rnd_ld_ready", ld_ready, e_lr);

      if (r_rst) begin
        model_reset();
        pa = 0;
        pl = 0;
      end else begin
        m_wre = got;
        if (got) begin
          m_a3  = winner_ld ? pl_addr : pa_addr;
          m_wd3 = winner_ld ? pl_data : pa_data;
          m_busy[m_a3] = 1'b0;
          if (pa && pl) m_pref = winner_ld ? 0 : 1;
          if (winner_ld) pl = 0; else pa = 0;
        end
        if (issue_valid && e_ir) m_busy[issue_addr] = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vreg_wb_arbiter.md
VREG_WB_ARBITER -- requirements
Module: vreg_wb_arbiter

Interface
REQ-001 Parameter NREG, default 32: number of vector registers tracked.
REQ-002 Parameter AW, default 5: register address width; SHALL equal clog2(NREG).
REQ-003 Parameter DW, default 128: vector data width.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 issue_valid  in  1  decoder requests reservation of a destination register.
REQ-007 issue_addr  in  AW  destination register to reserve.
REQ-008 issue_ready  out  1  reservation accepted this cycle (combinational).
REQ-009 alu_valid / alu_addr / alu_data  in  1 / AW / DW  vector ALU write-back request.
REQ-010 alu_ready  out  1  ALU request granted this cycle (combinational).
REQ-011 ld_valid / ld_addr / ld_data  in  1 / AW / DW  vector load unit write-back request.
REQ-012 ld_ready  out  1  load request granted this cycle (combinational).
REQ-013 wre / a3 / wd3  out  1 / AW / DW  registered drive of the register-file write port.
REQ-014 chk_a1, chk_a2  in  AW  source registers of the instruction in decode.
REQ-015 hazard  out  1  a source register has a pending write (combinational).
REQ-016 busy  out  NREG  scoreboard, bit i = register i has a reservation outstanding.

Function
REQ-017 issue_ready SHALL equal ~busy[issue_addr] & ~rst; an issue is accepted when issue_valid & issue_ready (WAW stall otherwise).
REQ-018 An accepted issue SHALL set busy[issue_addr] at the next posedge.
REQ-019 Arbitration: one grant per cycle; alone-valid requester always granted; when both valid, the requester named by rr_ptr is granted.
REQ-020 rr_ptr SHALL toggle to the non-granted requester after every contested grant and SHALL remain unchanged after an uncontested grant or an idle cycle.
REQ-021 alu_ready / ld_ready SHALL be asserted only for the granted requester and never while rst=1; requesters SHALL hold addr/data stable until ready.
REQ-022 Latency: a grant at posedge N SHALL present wre=1 with the granted addr/data on a3/wd3 from edge N to N+1 (one cycle); wre=0 in cycles with no grant.
REQ-023 a3/wd3 SHALL hold their last values when wre=0.
REQ-024 A grant SHALL clear busy[granted addr] at the same posedge wre is loaded.
REQ-025 Same-edge set and clear of the same register (issue accepted for X while a write to X is granted) SHALL leave busy[X]=1 (set wins).
REQ-026 A write-back to a register with busy=0 SHALL be forwarded to the port unchanged and SHALL leave busy unaffected.
REQ-027 hazard SHALL equal busy[chk_a1] | busy[chk_a2]; hazard SHALL NOT bypass data.
REQ-028 Back-to-back grants SHALL sustain one write per cycle with no bubble.
REQ-029 Addresses are unsigned; no register is hard-wired; register 0 is tracked like any other.

Reset
REQ-030 While rst=1 at a posedge: busy=0, wre=0, a3=0, wd3=0, rr_ptr=ALU; all ready outputs 0.
REQ-031 Reset mid-operation SHALL discard in-flight requests and reservations without a write; the first grant is available in the first cycle after rst deasserts.

Verification
REQ-032 Issue r7, then ALU writes r7 with data 0xA5..A5 -> busy[7] 1 then 0; wre=1, a3=7, wd3=0xA5..A5 for exactly one cycle.
REQ-033 ALU (r3) and load (r4) valid together for 4 cycles after reset -> grants ALU, LD, ALU, LD; a3 sequence 3,4,3,4 back-to-back.
REQ-034 busy[9]=1, issue r9 -> issue_ready=0, busy unchanged; after write to r9 the next issue of r9 is accepted.
REQ-035 Issue r5 and grant write to r5 at the same edge -> busy[5]=1 after the edge, wre=1 with a3=5.
REQ-036 busy[2]=1, chk_a1=2, chk_a2=6 -> hazard=1; chk_a1=1 -> hazard=0.
REQ-037 rst asserted while both requesters valid and busy=0xFFFF_FFFF -> next cycle busy=0, wre=0, ready=0; after release ALU granted first.
